random_pulse_gen_mc: RTL and testbench

Multi-channel, parametrised random pulse generator. It is the next generation of the single-channel LFSR pulse source. Each channel runs an independent maximal-length LFSR and compares its state against a threshold selected by a 2-bit frequency code. On a trigger the channel emits a programmable-width pulse, then enforces a programmable hold-off. The block adds per-channel enable, runtime seed loading and saturating pulse counters, and feeds stimulus/actuator logic that needs several uncorrelated random pulse streams.

---
 rtl/random_pulse_gen_mc.sv | 195 +++++++++++++++++++
 tb/tb_random_pulse_gen_mc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/random_pulse_gen_mc.sv
// Multi-channel LFSR random pulse generator: per-channel maximal-length LFSR, threshold
// trigger, programmable pulse width / hold-off and saturating pulse counters.

module random_pulse_gen_ch #(
    parameter int              WIDTH    = 32,
    parameter int              LEN_W    = 4,
    parameter logic [WIDTH-1:0] RST_SEED = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       freq,
    input  logic [LEN_W-1:0] pulse_len,
    input  logic [LEN_W-1:0] holdoff,
    input  logic             seed_ld,
    input  logic [WIDTH-1:0] seed_data,
    input  logic             cnt_clear,
    output logic             pulse_nx,
    output logic             pulse,
    output logic [15:0]      cnt
);
    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           st, st_nx;
    logic [LEN_W-1:0] len_cnt, len_nx, hold_cnt, hold_nx;
    logic [15:0]      cnt_nx;
    logic [WIDTH-1:0] lfsr, lfsr_nx, thresh;
    logic             fb, trig, inc;

    if (WIDTH == 32) begin : g_fb32
        assign fb = lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0];
    end else begin : g_fb16
        assign fb = lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3];
    end

    always_comb begin
        case (freq)
            2'd0:    thresh = ONE << (WIDTH - 12);
            2'd1:    thresh = ONE << (WIDTH - 13);
            2'd2:    thresh = ONE << (WIDTH - 14);
            default: thresh = ONE << (WIDTH - 15);
        endcase
    end

    assign trig = en & (lfsr < thresh);

    // A seed load wins over the shift; an all-zero seed would lock the LFSR, so it becomes 1.
    always_comb begin
        lfsr_nx = lfsr;
        if (seed_ld)
            lfsr_nx = (seed_data == '0) ? ONE : seed_data;
        else if (en)
            lfsr_nx = {lfsr[WIDTH-2:0], fb};
    end

    always_comb begin
        st_nx   = st;
        len_nx  = len_cnt;
        hold_nx = hold_cnt;
        inc     = 1'b0;
        if (!en) begin
            st_nx = IDLE;
        end else begin
            case (st)
                IDLE: begin
                    if (trig) begin
                        st_nx  = PULSE;
                        len_nx = pulse_len;
                        inc    = 1'b1;
                    end
                end
                PULSE: begin
                    if (len_cnt == '0) begin
                        if (holdoff == '0) begin
                            st_nx = IDLE;
                        end else begin
                            st_nx   = HOLD;
                            hold_nx = holdoff;
                        end
                    end else begin
                        len_nx = len_cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) st_nx = IDLE;
                    else                hold_nx = hold_cnt - 1'b1;
                end
                default: st_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_nx = cnt;
        if (cnt_clear)
            cnt_nx = '0;
        else if (inc && cnt != 16'hFFFF)
            cnt_nx = cnt + 16'd1;
    end

    assign pulse_nx = (st_nx == PULSE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st       <= IDLE;
            len_cnt  <= '0;
            hold_cnt <= '0;
            cnt      <= '0;
            lfsr     <= RST_SEED;
            pulse    <= 1'b0;
        end else begin
            st       <= st_nx;
            len_cnt  <= len_nx;
            hold_cnt <= hold_nx;
            cnt      <= cnt_nx;
            lfsr     <= lfsr_nx;
            pulse    <= pulse_nx;
        end
    end
endmodule

module random_pulse_gen_mc #(
    parameter int          WIDTH        = 32,
    parameter int          CHANNELS     = 4,
    parameter int          LEN_W        = 4,
    parameter logic [31:0] DEFAULT_SEED = 32'h0AAAAAAA
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CHANNELS-1:0]    enable,
    input  logic [2*CHANNELS-1:0]  frequency,
    input  logic [LEN_W-1:0]       pulse_len,
    input  logic [LEN_W-1:0]       holdoff,
    input  logic                   seed_valid,
    input  logic [2:0]             seed_ch,
    input  logic [WIDTH-1:0]       seed_data,
    input  logic                   cnt_clear,
    output logic [CHANNELS-1:0]    pulse,
    output logic                   pulse_any,
    output logic [16*CHANNELS-1:0] pulse_count
);
    if (WIDTH != 16 && WIDTH != 32) begin : g_bad_width
        $error("random_pulse_gen_mc: WIDTH must be 16 or 32");
    end
    if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
        $error("random_pulse_gen_mc: CHANNELS must be 1..8");
    end

    typedef struct packed {
        logic        pulse_nx;
        logic        pulse;
        logic [15:0] cnt;
    } ch_rsp_t;

    localparam logic [WIDTH-1:0] BASE_SEED = DEFAULT_SEED[WIDTH-1:0];

    ch_rsp_t [CHANNELS-1:0] rsp;
    logic    [CHANNELS-1:0] pulse_nx_vec;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        localparam logic [WIDTH-1:0] SEED_X = BASE_SEED ^ WIDTH'(c + 1);
        localparam logic [WIDTH-1:0] SEED_C = (SEED_X == '0) ? WIDTH'(1) : SEED_X;

        random_pulse_gen_ch #(
            .WIDTH    (WIDTH),
            .LEN_W    (LEN_W),
            .RST_SEED (SEED_C)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (enable[c]),
            .freq      (frequency[2*c+1:2*c]),
            .pulse_len (pulse_len),
            .holdoff   (holdoff),
            .seed_ld   (seed_valid && (seed_ch == 3'(c))),
            .seed_data (seed_data),
            .cnt_clear (cnt_clear),
            .pulse_nx  (rsp[c].pulse_nx),
            .pulse     (rsp[c].pulse),
            .cnt       (rsp[c].cnt)
        );

        assign pulse_nx_vec[c]         = rsp[c].pulse_nx;
        assign pulse[c]                = rsp[c].pulse;
        assign pulse_count[16*c +: 16] = rsp[c].cnt;
    end

    // Registered from the next-cycle pulse values so it lines up with pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pulse_any <= 1'b0;
        else        pulse_any <= |pulse_nx_vec;
    end
endmodule

// File: tb/tb_random_pulse_gen_mc.sv
// Scoreboard bench for random_pulse_gen_mc (WIDTH=32, CHANNELS=4): a behavioural model
// predicts every cycle's outputs and LFSR states, queued at drive time and compared after the edge.

module tb_random_pulse_gen_mc;
    logic        clk;
    logic        rst_n;
    logic [3:0]  enable;
    logic [7:0]  frequency;
    logic [3:0]  pulse_len, holdoff;
    logic        seed_valid;
    logic [2:0]  seed_ch;
    logic [31:0] seed_data;
    logic        cnt_clear;
    logic [3:0]  pulse;
    logic        pulse_any;
    logic [63:0] pulse_count;

    random_pulse_gen_mc #(.WIDTH(32), .CHANNELS(4), .LEN_W(4), .DEFAULT_SEED(32'h0AAAAAAA)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .frequency(frequency),
        .pulse_len(pulse_len), .holdoff(holdoff), .seed_valid(seed_valid),
        .seed_ch(seed_ch), .seed_data(seed_data), .cnt_clear(cnt_clear),
        .pulse(pulse), .pulse_any(pulse_any), .pulse_count(pulse_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       pulse;
        logic             any;
        logic [3:0][15:0] cnt;
        logic [3:0][31:0] lfsr;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    logic [31:0] m_lfsr[4];
    int          m_st[4];   // 0 idle, 1 pulse, 2 hold
    logic [3:0]  m_len[4], m_hold[4];
    logic [15:0] m_cnt[4];
    logic [3:0]  m_pulse;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic [31:0] get_lfsr(input int c);
        case (c)
            0:       return dut.g_ch[0].u_ch.lfsr;
            1:       return dut.g_ch[1].u_ch.lfsr;
            2:       return dut.g_ch[2].u_ch.lfsr;
            default: return dut.g_ch[3].u_ch.lfsr;
        endcase
    endfunction

    function automatic logic [31:0] m_thr(input logic [1:0] f);
        return 32'h1 << (20 - int'(f));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            m_lfsr[c] = 32'h0AAAAAAA ^ 32'(c + 1);
            m_st[c]   = 0;
            m_len[c]  = '0;
            m_hold[c] = '0;
            m_cnt[c]  = '0;
        end
        m_pulse = '0;
    endtask

    function automatic bit m_will_inc(input int c);
        return m_st[c] == 0 && enable[c] && (m_lfsr[c] < m_thr(frequency[2*c +: 2]));
    endfunction

    task automatic model_step();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            bit          en, trig, inc;
            logic [31:0] nl;
            int          ns;
            en   = enable[c];
            trig = en && (m_lfsr[c] < m_thr(frequency[2*c +: 2]));
            inc  = 0;
            ns   = m_st[c];
            if (seed_valid && int'(seed_ch) == c) nl = (seed_data == 0) ? 32'd1 : seed_data;
            else if (en) nl = {m_lfsr[c][30:0], m_lfsr[c][31] ^ m_lfsr[c][21] ^ m_lfsr[c][1] ^ m_lfsr[c][0]};
            else nl = m_lfsr[c];
            if (!en) ns = 0;
            else if (m_st[c] == 0) begin
                if (trig) begin ns = 1; m_len[c] = pulse_len; inc = 1; end
            end else if (m_st[c] == 1) begin
                if (m_len[c] == 0) begin
                    if (holdoff == 0) ns = 0;
                    else begin ns = 2; m_hold[c] = holdoff; end
                end else m_len[c] = m_len[c] - 1;
            end else begin
                if (m_hold[c] == 0) ns = 0;
                else m_hold[c] = m_hold[c] - 1;
            end
            if (cnt_clear) m_cnt[c] = 0;
            else if (inc && m_cnt[c] != 16'hFFFF) m_cnt[c] = m_cnt[c] + 1;
            m_st[c]    = ns;
            m_lfsr[c]  = nl;
            m_pulse[c] = (ns == 1);
            e.cnt[c]   = m_cnt[c];
            e.lfsr[c]  = nl;
        end
        e.pulse = m_pulse;
        e.any   = |m_pulse;
        sb_q.push_back(e);
    endtask

    // Predict this edge, let it happen, then compare away from the edge.
    task automatic cycle();
        exp_t e;
        model_step();
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("pulse", 64'(pulse), 64'(e.pulse));
        chk("pulse_any", 64'(pulse_any), 64'(e.any));
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("cnt%0d", c), 64'(pulse_count[16*c +: 16]), 64'(e.cnt[c]));
            chk($sformatf("lfsr%0d", c), 64'(get_lfsr(c)), 64'(e.lfsr[c]));
        end
    endtask

    task automatic load_seed(input int ch, input logic [31:0] d);
        seed_valid = 1'b1; seed_ch = 3'(ch); seed_data = d;
        cycle();
        seed_valid = 1'b0;
    endtask

    initial begin
        int  hi, gap, wcnt;
        bit  found;
        rst_n = 1'b0; enable = 4'hF; frequency = 8'h00; pulse_len = 4'd2; holdoff = 4'd3;
        seed_valid = 1'b0; seed_ch = 3'd0; seed_data = '0; cnt_clear = 1'b0;
        model_reset();
        #12;
        chk("rst_lfsr0", 64'(get_lfsr(0)), 64'h0AAAAAAB);
        chk("rst_lfsr3", 64'(get_lfsr(3)), 64'h0AAAAAAE);
        chk("rst_pulse", 64'(pulse), 64'h0);
        chk("rst_any", 64'(pulse_any), 64'h0);
        chk("rst_cnt", pulse_count, 64'h0);
        rst_n = 1'b1;

        // 1: free-running sequences, then randomised control traffic
        for (int i = 0; i < 10000; i++) cycle();
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) enable = 4'($urandom);
            else if ($urandom_range(0, 3) == 0) enable = 4'hF;
            frequency  = 8'($urandom);
            seed_valid = ($urandom_range(0, 15) == 0);
            seed_ch    = 3'($urandom_range(0, 7));
            seed_data  = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(0, 32'h1FFFFF));
            if ($urandom_range(0, 31) == 0) pulse_len = 4'($urandom);
            if ($urandom_range(0, 31) == 0) holdoff = 4'($urandom);
            cnt_clear  = ($urandom_range(0, 63) == 0);
            cycle();
        end
        seed_valid = 1'b0; cnt_clear = 1'b0; enable = 4'hF; frequency = 8'h00;
        for (int i = 0; i < 40; i++) cycle();

        // 2: seeded trigger, width and hold-off
        pulse_len = 4'd3; holdoff = 4'd5;
        while (m_st[1] != 0) cycle();
        load_seed(1, 32'h5);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) if (pulse[1]) found = 1; else cycle();
        chk("t2_rise", 64'(found), 64'h1);
        chk("t2_cnt", 64'(pulse_count[31:16]), 64'(m_cnt[1]));
        hi = 0;
        while (pulse[1] && hi < 30) begin hi++; cycle(); end
        chk("t2_high", 64'(hi), 64'd4);
        gap = 0;
        while (!pulse[1] && gap < 30) begin gap++; cycle(); end
        chk("t2_gap_ge6", 64'(gap >= 6), 64'h1);

        // 3: zero seed loads 1
        load_seed(2, 32'h0);
        chk("t3_ld", 64'(get_lfsr(2)), 64'h1);
        cycle();
        chk("t3_adv", 64'(get_lfsr(2)), 64'h3);

        // 4: disable mid-pulse
        pulse_len = 4'd15; holdoff = 4'd0;
        for (int i = 0; i < 40; i++) cycle();
        while (m_st[0] != 0) cycle();
        load_seed(0, 32'h5);
        wcnt = 0;
        while (!pulse[0] && wcnt < 20) begin wcnt++; cycle(); end
        chk("t4_rise", 64'(pulse[0]), 64'h1);
        cycle(); cycle();
        enable[0] = 1'b0;
        cycle();
        chk("t4_off", 64'(pulse[0]), 64'h0);
        for (int i = 0; i < 5; i++) cycle();
        enable[0] = 1'b1;
        for (int i = 0; i < 30; i++) cycle();

        // 5: saturation and clear-over-increment
        enable = 4'b1000; frequency = 8'hFF; pulse_len = 4'd0; holdoff = 4'd0;
        cycle();
        force dut.g_ch[3].u_ch.cnt = 16'hFFF8;
        #1;
        release dut.g_ch[3].u_ch.cnt;
        m_cnt[3] = 16'hFFF8;
        for (int i = 0; i < 60; i++) begin
            seed_valid = (i % 8 == 0); seed_ch = 3'd3; seed_data = 32'h1;
            cycle();
        end
        chk("t5_sat", 64'(pulse_count[63:48]), 64'hFFFF);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            seed_valid = (i % 8 == 0);
            if (m_will_inc(3)) found = 1; else cycle();
        end
        seed_valid = 1'b0;
        chk("t5_inc_found", 64'(found), 64'h1);
        cnt_clear = 1'b1;
        cycle();
        cnt_clear = 1'b0;
        chk("t5_clr", 64'(pulse_count[63:48]), 64'h0);

        // 6: asynchronous reset mid-pulse
        enable = 4'hF; frequency = 8'h00; pulse_len = 4'd7; holdoff = 4'd2;
        for (int i = 0; i < 30; i++) cycle();
        while (m_st[0] != 0) cycle();
        load_seed(0, 32'h5);
        wcnt = 0;
        while (!pulse[0] && wcnt < 20) begin wcnt++; cycle(); end
        chk("t6_pre", 64'(pulse[0]), 64'h1);
        chk("t6_pre_cnt", 64'(pulse_count[15:0] != 0), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_pulse", 64'(pulse), 64'h0);
        chk("t6_any", 64'(pulse_any), 64'h0);
        chk("t6_cnt", pulse_count, 64'h0);
        model_reset();
        #2 rst_n = 1'b1;
        chk("t6_lfsr0", 64'(get_lfsr(0)), 64'h0AAAAAAB);
        chk("t6_lfsr1", 64'(get_lfsr(1)), 64'h0AAAAAA8);
        for (int i = 0; i < 50; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
